shift_serializer: RTL and testbench
===================================

Name: shift_serializer

Overview:
- Parametrised successor to the team's single-word shift register.
- Parallel-in, serial-out block with valid/ready handshakes on both sides.
- Per-word programmable bit length and bit order (MSB-first or LSB-first).
- One-entry staging buffer, so consecutive words go out back-to-back with no idle cycle; used ahead of serial links (SPI/UART-style framers) in the common registers library.

Parameters:
- DATA_WIDTH, 32, maximum word width in bits (must be >= 2).
- LEN_W, $clog2(DATA_WIDTH), width of the length field.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_clear  input  1  synchronous clear; discards staged and in-flight words.
- i_valid  input  1  parallel word valid.
- o_ready  output  1  block can accept a parallel word.
- i_data  input  DATA_WIDTH  parallel word.
- i_len  input  LEN_W  number of bits to send minus 1.
- i_lsb_first  input  1  1 = send bit 0 first; 0 = send bit i_len first.
- o_valid  output  1  serial bit valid.
- i_ready  input  1  downstream accepts the serial bit.
- o_sdata  output  1  serial bit.
- o_last  output  1  current serial bit is the final bit of its word.
- o_busy  output  1  staging buffer full or shifter active.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Staging buffer empty, shifter idle, bit counter cleared.
  - o_valid=0, o_sdata=0, o_last=0, o_busy=0, o_ready=1.
- Input transfer:
  - Occurs on a rising edge with i_valid && o_ready.
  - i_data, i_len and i_lsb_first are captured together into the staging buffer.
  - o_ready = !stage_full; it is combinational from the register state only, never from i_valid.
- Shifter states: IDLE and SHIFT.
  - IDLE -> SHIFT: at the edge where the staging buffer is full. The shifter loads data, length and order from the staging buffer, and the staging buffer empties.
  - SHIFT: o_valid=1. A serial transfer occurs on an edge with o_valid && i_ready.
- Bit selection and hold:
  - MSB-first sends bits i_len, i_len-1, ..., 0.
  - LSB-first sends bits 0, 1, ..., i_len.
  - Bits above i_len are ignored.
  - o_sdata and o_last hold stable while o_valid && !i_ready.
- End of word:
  - o_last=1 exactly on the (i_len+1)-th bit.
  - On that bit's transfer edge, if the staging buffer is full, the shifter reloads from it in the same edge. o_valid stays 1 and the next word's first bit appears in the following cycle (zero bubble).
  - If the staging buffer is empty, the shifter goes to IDLE and o_valid=0.
- Latency: input transfer at edge N gives o_valid=1 after edge N+1 when the shifter is idle.
- Length rules:
  - i_len is taken modulo the LEN_W field.
  - Values >= DATA_WIDTH are clamped to DATA_WIDTH-1.
  - i_len=0 gives a single-bit word with o_last=1 on that bit.
- Throughput:
  - Staging accepts a new word the cycle after it empties, not on the same edge.
  - Words of 1 bit therefore sustain one word every 2 cycles.
  - Words of 2 or more bits run back-to-back with no bubble.
- o_busy = stage_full || (state==SHIFT).
- i_clear:
  - Takes priority over every transfer on that edge.
  - Empties staging, returns to IDLE and drops o_valid/o_last.
  - Any word offered on that edge is not accepted.
- Reset mid-word: the word is lost, and the block restarts in the reset state; no partial output resumes.
- Bit counter: LEN_W+1 bits wide; no wrap-around for any legal length.

Test Plan:
- DATA_WIDTH=8, load 8'hA5, i_len=7, MSB-first, i_ready=1 -> o_sdata 1,0,1,0,0,1,0,1; o_last on 8th bit; o_valid low afterwards.
- Same word with LSB-first -> o_sdata 1,0,1,0,0,1,0,1 reversed order (1,0,1,0,0,1,0,1 reads bit0..bit7 = 1,0,1,0,0,1,0,1); check that the bit index increments each bit.
- Load 8'h0D with i_len=3, LSB-first, then 8'hF0 with i_len=3, MSB-first, queued back-to-back -> serial stream 1,0,1,1 then 0,0,0,0; o_valid continuously high for 8 cycles; o_last on cycles 4 and 8.
- Toggle i_ready every other cycle during word 8'h3C -> each bit holds until accepted; exactly 8 transfers; o_ready=0 while a second word is staged.
- i_len=0 words streamed continuously -> one bit per word; o_last=1 on every bit; o_ready alternates, giving 1 word per 2 cycles.
- Assert i_clear (and separately rst_n) during the 3rd bit with a staged word -> o_valid=0 next cycle (immediately for rst_n); o_busy=0; o_ready=1; a subsequent load starts from bit 0 of the new word.

Source files
------------

// File: rtl/shift_serializer_if.sv
// Handshake bundle for shift_serializer: parallel word input side and serial bit output side.
interface shift_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = $clog2(DATA_WIDTH)
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [LEN_W-1:0]      i_len;
    logic                  i_lsb_first;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_sdata;
    logic                  o_last;
    logic                  o_busy;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_len,
        input  i_lsb_first,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_sdata,
        output o_last,
        output o_busy
    );

    modport master (
        output i_valid,
        output i_data,
        output i_len,
        output i_lsb_first,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_sdata,
        input  o_last,
        input  o_busy
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out shifter with a one-entry staging buffer and per-word length/bit order.
module shift_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = $clog2(DATA_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    shift_serializer_if.slave bus
);

    localparam int              CNT_W    = LEN_W + 1;
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_SHIFT = 1'b1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Bit index counts up for LSB-first and down from len for MSB-first.
    function automatic logic pick_bit(
        input logic [DATA_WIDTH-1:0] data,
        input logic [LEN_W-1:0]      len,
        input logic                  lsb_first,
        input logic [LEN_W-1:0]      cnt
    );
        logic [LEN_W-1:0] idx;
        idx = lsb_first ? cnt : (len - cnt);
        return data[idx];
    endfunction

    logic                  stage_full_r, stage_full_s;
    logic [DATA_WIDTH-1:0] stage_data_r, stage_data_s;
    logic [LEN_W-1:0]      stage_len_r,  stage_len_s;
    logic                  stage_lsb_r,  stage_lsb_s;
    logic [0:0]            state_r,      state_s;
    logic [DATA_WIDTH-1:0] sh_data_r,    sh_data_s;
    logic [LEN_W-1:0]      sh_len_r,     sh_len_s;
    logic                  sh_lsb_r,     sh_lsb_s;
    logic [CNT_W-1:0]      cnt_r,        cnt_s;
    logic                  valid_r,      valid_s;
    logic                  sdata_r,      sdata_s;
    logic                  last_r,       last_s;
    logic                  busy_r,       busy_s;

    logic                  accept_s;
    logic                  xfer_s;
    logic                  word_end_s;
    logic                  load_s;
    logic [LEN_W-1:0]      in_len_s;

    // Lengths beyond the word only exist when DATA_WIDTH is not a power of two.
    generate
        if ((1 << LEN_W) > DATA_WIDTH) begin : g_clamp
            assign in_len_s = (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
        end else begin : g_no_clamp
            assign in_len_s = bus.i_len;
        end
    endgenerate

    assign accept_s   = bus.i_valid && !stage_full_r;
    assign xfer_s     = valid_r && bus.i_ready;
    assign word_end_s = xfer_s && last_r;
    assign load_s     = stage_full_r && ((state_r == ST_IDLE) || word_end_s);

    // Next state of staging buffer, shifter and bit counter.
    always_comb begin
        stage_full_s = stage_full_r;
        stage_data_s = stage_data_r;
        stage_len_s  = stage_len_r;
        stage_lsb_s  = stage_lsb_r;
        state_s      = state_r;
        sh_data_s    = sh_data_r;
        sh_len_s     = sh_len_r;
        sh_lsb_s     = sh_lsb_r;
        cnt_s        = cnt_r;
        if (i_clear) begin
            stage_full_s = 1'b0;
            state_s      = ST_IDLE;
            cnt_s        = CNT_ZERO;
        end else begin
            if (load_s) begin
                stage_full_s = 1'b0;
            end else if (accept_s) begin
                stage_full_s = 1'b1;
                stage_data_s = bus.i_data;
                stage_len_s  = in_len_s;
                stage_lsb_s  = bus.i_lsb_first;
            end else begin
                stage_full_s = stage_full_r;
            end

            // A load on the final bit's edge gives back-to-back words.
            if (load_s) begin
                state_s   = ST_SHIFT;
                sh_data_s = stage_data_r;
                sh_len_s  = stage_len_r;
                sh_lsb_s  = stage_lsb_r;
                cnt_s     = CNT_ZERO;
            end else if (word_end_s) begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end else if (xfer_s) begin
                cnt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
        end
    end

    // Output values derived from the next state so that outputs come straight from flops.
    always_comb begin
        valid_s = (state_s == ST_SHIFT);
        busy_s  = stage_full_s || valid_s;
        if (valid_s) begin
            sdata_s = pick_bit(sh_data_s, sh_len_s, sh_lsb_s, cnt_s[LEN_W-1:0]);
            last_s  = (cnt_s == {1'b0, sh_len_s});
        end else begin
            sdata_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    // Staging buffer and shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_full_r <= 1'b0;
            stage_data_r <= {DATA_WIDTH{1'b0}};
            stage_len_r  <= {LEN_W{1'b0}};
            stage_lsb_r  <= 1'b0;
            state_r      <= ST_IDLE;
            sh_data_r    <= {DATA_WIDTH{1'b0}};
            sh_len_r     <= {LEN_W{1'b0}};
            sh_lsb_r     <= 1'b0;
            cnt_r        <= CNT_ZERO;
        end else begin
            stage_full_r <= stage_full_s;
            stage_data_r <= stage_data_s;
            stage_len_r  <= stage_len_s;
            stage_lsb_r  <= stage_lsb_s;
            state_r      <= state_s;
            sh_data_r    <= sh_data_s;
            sh_len_r     <= sh_len_s;
            sh_lsb_r     <= sh_lsb_s;
            cnt_r        <= cnt_s;
        end
    end

    // Registered serial-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            sdata_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= valid_s;
            sdata_r <= sdata_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.o_ready = !stage_full_r;
    assign bus.o_valid = valid_r;
    assign bus.o_sdata = sdata_r;
    assign bus.o_last  = last_r;
    assign bus.o_busy  = busy_r;

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: vector table, directed corner sequences, random stream vs model.
module tb_shift_serializer;

    localparam int DW = 8;
    localparam int LW = 3;

    logic clk;
    logic rst_n;
    logic i_clear;

    shift_serializer_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

    shift_serializer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (i_clear),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [2:0] len;
        logic       lsb;
        logic [7:0] seq;   // seq[k] is the k-th bit expected on the line
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic acc;
        acc = bus.i_valid && bus.o_ready && !i_clear;
        @(posedge clk);
        #1;
        if (acc) bus.i_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] d, input logic [2:0] l, input logic lsb);
        bus.i_data      = d;
        bus.i_len       = l;
        bus.i_lsb_first = lsb;
        bus.i_valid     = 1'b1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int nb;
        nb = int'(v.len) + 1;
        bus.i_ready = 1'b1;
        check($sformatf("v%0d_ready_idle", id), bus.o_ready, 1'b1);
        offer(v.data, v.len, v.lsb);
        tick();
        check($sformatf("v%0d_latency", id), bus.o_valid, 1'b0);
        check($sformatf("v%0d_staged", id), bus.o_ready, 1'b0);
        for (int k = 0; k < nb; k++) begin
            tick();
            check($sformatf("v%0d_valid%0d", id, k), bus.o_valid, 1'b1);
            check($sformatf("v%0d_bit%0d", id, k), bus.o_sdata, v.seq[k]);
            check($sformatf("v%0d_last%0d", id, k), bus.o_last, (k == nb - 1));
        end
        tick();
        check($sformatf("v%0d_done_valid", id), bus.o_valid, 1'b0);
        check($sformatf("v%0d_done_busy", id), bus.o_busy, 1'b0);
    endtask

    // Loads 8'hC7 MSB-first with 8'h55 staged behind it; returns while the third bit is on the line.
    task automatic start_two_words(input string tag);
        bus.i_ready = 1'b1;
        offer(8'hC7, 3'd7, 1'b0);
        tick();
        offer(8'h55, 3'd7, 1'b1);
        tick();
        tick();
        tick();
        check({tag, "_bit3_valid"}, bus.o_valid, 1'b1);
        check({tag, "_bit3_val"}, bus.o_sdata, 1'b0);
        check({tag, "_bit3_staged"}, bus.o_ready, 1'b0);
    endtask

    initial begin : main
        logic [7:0]  seq;
        logic [15:0] stream;
        logic [7:0]  wd[10];
        logic [1:0]  q[$];
        logic [1:0]  e;
        logic        acc, prev_hold, prev_sdata, prev_last, ready_done;
        int          ntx, sent, got, ready_err, bit_err, last_err, accepted, cyc;
        vec_t        w;

        vecs[0] = '{8'hA5, 3'd7, 1'b0, 8'hA5};
        vecs[1] = '{8'hA5, 3'd7, 1'b1, 8'hA5};
        vecs[2] = '{8'h1E, 3'd7, 1'b0, 8'h78};
        vecs[3] = '{8'h0D, 3'd3, 1'b1, 8'h0D};
        vecs[4] = '{8'hF0, 3'd3, 1'b0, 8'h00};
        vecs[5] = '{8'hC6, 3'd4, 1'b0, 8'h0C};
        vecs[6] = '{8'h01, 3'd0, 1'b0, 8'h01};
        vecs[7] = '{8'hB2, 3'd6, 1'b0, 8'h26};

        rst_n = 1'b0; i_clear = 1'b0;
        bus.i_valid = 1'b0; bus.i_data = 8'h00; bus.i_len = 3'd0;
        bus.i_lsb_first = 1'b0; bus.i_ready = 1'b1;
        #12;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_sdata", bus.o_sdata, 1'b0);
        check("rst_last", bus.o_last, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_ready", bus.o_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back: 0D LSB-first then F0 MSB-first, no bubble
        seq = 8'h0D;
        offer(8'h0D, 3'd3, 1'b1);
        tick();
        offer(8'hF0, 3'd3, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b_valid%0d", k), bus.o_valid, 1'b1);
            check($sformatf("b2b_bit%0d", k), bus.o_sdata, seq[k]);
            check($sformatf("b2b_last%0d", k), bus.o_last, (k == 3 || k == 7));
            tick();
        end
        check("b2b_end_valid", bus.o_valid, 1'b0);
        check("b2b_end_busy", bus.o_busy, 1'b0);

        // i_ready toggling on 3C with 81 staged behind it
        stream = {8'h81, 8'h3C};
        bus.i_ready = 1'b0;
        offer(8'h3C, 3'd7, 1'b0);
        tick();
        offer(8'h81, 3'd7, 1'b1);
        ntx = 0; prev_hold = 1'b0; prev_sdata = 1'b0; prev_last = 1'b0; ready_done = 1'b0;
        for (int c = 0; c < 60 && ntx < 16; c++) begin
            if (prev_hold) begin
                check("hold_valid", bus.o_valid, 1'b1);
                check("hold_sdata", bus.o_sdata, prev_sdata);
                check("hold_last", bus.o_last, prev_last);
            end
            bus.i_ready = c[0];
            if (bus.o_valid && bus.i_ready) begin
                check($sformatf("tog_bit%0d", ntx), bus.o_sdata, stream[ntx]);
                check($sformatf("tog_last%0d", ntx), bus.o_last, (ntx == 7 || ntx == 15));
                ntx++;
            end
            if (ntx == 4 && !ready_done) begin
                check("tog_staged_ready", bus.o_ready, 1'b0);
                ready_done = 1'b1;
            end
            prev_hold  = bus.o_valid && !bus.i_ready;
            prev_sdata = bus.o_sdata;
            prev_last  = bus.o_last;
            tick();
        end
        check("tog_count", ntx, 16);
        check("tog_end_valid", bus.o_valid, 1'b0);
        check("tog_end_busy", bus.o_busy, 1'b0);

        // Single-bit words streamed continuously
        bus.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) wd[i] = 8'($urandom);
        sent = 0; got = 0; ready_err = 0; bit_err = 0; last_err = 0;
        for (int c = 0; c < 22; c++) begin
            if (sent < 10) offer(wd[sent], 3'd0, c[1]);
            if (c < 20 && bus.o_ready !== (c % 2 == 0)) ready_err++;
            if (bus.o_valid) begin
                if (got < 10 && bus.o_sdata !== wd[got][0]) bit_err++;
                if (bus.o_last !== 1'b1) last_err++;
                got++;
            end
            acc = bus.i_valid && bus.o_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                bus.i_valid = 1'b0;
            end
        end
        check("len0_ready_alternates", ready_err, 0);
        check("len0_bits", bit_err, 0);
        check("len0_last", last_err, 0);
        check("len0_words", got, 10);
        check("len0_end_busy", bus.o_busy, 1'b0);

        // i_clear during the third bit with a staged word
        start_two_words("clr");
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_valid", bus.o_valid, 1'b0);
        check("clr_last", bus.o_last, 1'b0);
        check("clr_busy", bus.o_busy, 1'b0);
        check("clr_ready", bus.o_ready, 1'b1);
        tick();
        check("clr_no_resume", bus.o_valid, 1'b0);
        w = '{8'h96, 3'd7, 1'b1, 8'h96};
        run_vec(20, w);

        // A word offered on a clear edge is dropped
        offer(8'hFF, 3'd0, 1'b0);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        bus.i_valid = 1'b0;
        check("clr_offer_busy", bus.o_busy, 1'b0);
        tick();
        check("clr_offer_valid", bus.o_valid, 1'b0);

        // Asynchronous reset during the third bit
        start_two_words("rst");
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", bus.o_valid, 1'b0);
        check("rstmid_sdata", bus.o_sdata, 1'b0);
        check("rstmid_busy", bus.o_busy, 1'b0);
        check("rstmid_ready", bus.o_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        check("rstmid_no_resume", bus.o_valid, 1'b0);
        w = '{8'h4B, 3'd7, 1'b0, 8'hD2};
        run_vec(21, w);

        // Random words and back-pressure against a bit-stream model
        accepted = 0; cyc = 0; prev_hold = 1'b0;
        while ((accepted < 40 || q.size() > 0) && cyc < 3000) begin
            if (prev_hold) begin
                check("rnd_hold_valid", bus.o_valid, 1'b1);
                check("rnd_hold_sdata", bus.o_sdata, prev_sdata);
                check("rnd_hold_last", bus.o_last, prev_last);
            end
            bus.i_ready = (accepted >= 40) ? 1'b1 : ($urandom_range(3) != 0);
            if (bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) begin
                    check("rnd_extra_bit", bus.o_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("rnd_sdata", bus.o_sdata, e[1]);
                    check("rnd_last", bus.o_last, e[0]);
                end
            end
            if (!bus.i_valid && accepted < 40 && $urandom_range(1) == 1)
                offer(8'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)));
            acc = bus.i_valid && bus.o_ready;
            if (acc) begin
                for (int j = 0; j <= int'(bus.i_len); j++) begin
                    int idx;
                    idx = bus.i_lsb_first ? j : int'(bus.i_len) - j;
                    q.push_back({bus.i_data[idx], (j == int'(bus.i_len))});
                end
            end
            prev_hold  = bus.o_valid && !bus.i_ready;
            prev_sdata = bus.o_sdata;
            prev_last  = bus.o_last;
            @(posedge clk); #1;
            if (acc) begin
                accepted++;
                bus.i_valid = 1'b0;
            end
            cyc++;
        end
        check("rnd_accepted", accepted, 40);
        check("rnd_drained", q.size(), 0);
        check("rnd_end_valid", bus.o_valid, 1'b0);
        check("rnd_end_busy", bus.o_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
